button_arbiter: RTL and testbench
=================================

Name: button_arbiter

Overview:
- Front end for up to N raw push-button inputs feeding the processor control unit.
- Per channel: synchronises the asynchronous input (two flip-flops), detects rising edges, applies a re-trigger lockout and latches one pending press.
- A round-robin arbiter issues one command ID at a time to the consumer over a valid/ready handshake. This replaces per-button synchroniser instances and ad hoc priority logic.

Parameters:
- N, 4, number of button channels (2..8).
- LOCKOUT, 4, cycles after an accepted press during which further edges on that channel are ignored (>=1).
- IW, $clog2(N), width of CmdId.

Ports:
- Clock  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- In  input  N  raw, asynchronous button levels, active high.
- CmdReady  input  1  consumer accepts the offered command this cycle.
- OvrClr  input  1  synchronous pulse; clears all Overrun bits.
- CmdValid  output  1  command offered; registered.
- CmdId  output  IW  index of the granted channel; registered.
- Pending  output  N  per-channel pending-press flags; registered.
- Overrun  output  N  sticky per-channel dropped-press flags; registered.

Behaviour:
- Reset: ResetN low asynchronously clears the following immediately, regardless of Clock:
  - all sync/edge flops;
  - lockout counters;
  - Pending, Overrun, CmdValid, CmdId = 0;
  - FSM = IDLE;
  - Ptr = N-1.
- Reset asserted mid-offer drops the offered command; no partial state survives.
- Synchroniser per channel: S1 <= In[i], S2 <= S1, S3 <= S2. Press[i] = S2 & ~S3 & (LockCnt[i] == 0).
- Latency: In[i] high before edge k gives S2 = 1 after edge k+1 and Pending[i] = 1 after edge k+2, if not locked out.
- Lockout: when Press[i] is true, LockCnt[i] loads LOCKOUT at the same edge, then decrements each cycle to 0. Rising edges of S2 while LockCnt != 0 are ignored and do not set Overrun.
- Pending set/clear per edge:
  - Press[i] and not granted this edge: Pending[i] <= 1.
  - Pending[i] already 1 and Press[i] and not granted this edge: the press is dropped and Overrun[i] <= 1.
  - Granted this edge without Press[i]: Pending[i] <= 0.
  - Grant and Press on the same channel at the same edge: Pending[i] stays 1, no overrun.
- Overrun: cleared only by OvrClr or reset. If OvrClr and a new overrun coincide on a channel, the overrun wins (bit = 1).
- Round-robin winner: first i with Pending[i] = 1, searching (Ptr+1) mod N upward and wrapping. Pending is sampled as registered, so presses arriving this cycle are not visible.
- FSM IDLE: CmdValid = 0. If any Pending bit is set, at the next edge: CmdId <= winner, CmdValid <= 1, clear Pending[winner], Ptr <= winner, go to OFFER. Otherwise stay in IDLE.
- FSM OFFER: CmdValid = 1 with CmdId held stable.
  - CmdReady high at an edge: handshake completes, CmdValid <= 0, go to IDLE.
  - CmdReady low: remain in OFFER indefinitely; no new grant.
- Throughput: at most one command per 2 cycles (mandatory IDLE cycle between offers).
- CmdReady while in IDLE is ignored.
- Channels with In held high produce exactly one press; release and re-press is required after lockout expiry.
- Metastability: only S1 may go metastable; no logic other than S2 reads S1.

Test Plan:
- Reset/latency: hold ResetN = 0 for 3 cycles, then release with In = 0000.
  - Required: all outputs 0.
  - Raise In[2] before edge k: Pending = 0100 after edge k+2. With CmdReady held at 0: CmdValid = 1, CmdId = 2 after edge k+3, and Pending = 0000 after edge k+3.
- Handshake hold: offer CmdId = 2 with CmdReady = 0 for 5 cycles.
  - Required: CmdValid and CmdId stay unchanged.
  - Drive CmdReady = 1 for one edge: CmdValid = 0 the next cycle.
- Round-robin fairness: In = 1111 pulsed together, CmdReady tied high.
  - Required: issued IDs 0, 1, 2, 3 on alternating cycles.
  - Repeat the pulse: order is again 0, 1, 2, 3 (Ptr = 3 wraps to 0).
- Lockout with LOCKOUT = 4: toggle In[1] high/low/high with 2-cycle spacing.
  - Required: exactly one press latched and Overrun[1] = 0.
  - A re-press after the counter reaches 0 latches a second press.
- Overrun: CmdReady = 0 while channel 0 is offered; press channel 3 twice, outside lockout.
  - Required: Pending[3] = 1 and Overrun[3] = 1.
  - OvrClr pulse: Overrun = 0000 and Pending[3] is still 1.
- Async reset mid-offer: drop ResetN between clock edges while CmdValid = 1.
  - Required: CmdValid = 0 and Pending = 0000 immediately, before the next edge.

Source files
------------

// File: rtl/button_arbiter.sv
// Push-button front end: per-channel synchroniser, edge detect, lockout
// and pending latch, plus a round-robin command issuer.
module button_arbiter #(
    parameter int N       = 4,
    parameter int LOCKOUT = 4,
    parameter int IW      = $clog2(N)
) (
    input  logic          Clock,
    input  logic          ResetN,
    input  logic [N-1:0]  In,
    input  logic          CmdReady,
    input  logic          OvrClr,
    output logic          CmdValid,
    output logic [IW-1:0] CmdId,
    output logic [N-1:0]  Pending,
    output logic [N-1:0]  Overrun
);

    localparam int CW = $clog2(LOCKOUT + 1);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t          state;
    logic [N-1:0]    s1;
    logic [N-1:0]    s2;
    logic [N-1:0]    s3;
    logic [CW-1:0]   lock_cnt [N];
    logic [N-1:0]    press;
    logic [N-1:0]    grant;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    int              off;
    int              wsum;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            press[i] = s2[i] & ~s3[i] & (lock_cnt[i] == '0);
        end
    end

    // Rotate Pending so the search starts just after the last winner.
    always_comb begin
        dbl  = {Pending, Pending} >> (ptr + 1'b1);
        rot  = dbl[N-1:0];
        off  = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end
        wsum = int'(ptr) + 1 + off;
        if (wsum >= N) begin
            wsum = wsum - N;
        end
        winner = IW'(wsum);
    end

    always_comb begin
        grant = '0;
        if (state == IDLE && |Pending) begin
            grant[winner] = 1'b1;
        end
    end

    // Only s2 reads s1; s1 is the metastability-absorbing stage.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            for (int i = 0; i < N; i++) begin
                lock_cnt[i] <= '0;
            end
        end else begin
            s1 <= In;
            s2 <= s1;
            s3 <= s2;
            for (int i = 0; i < N; i++) begin
                if (press[i]) begin
                    lock_cnt[i] <= CW'(LOCKOUT);
                end else if (lock_cnt[i] != '0) begin
                    lock_cnt[i] <= lock_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Pending <= '0;
            Overrun <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    Pending[i] <= press[i];
                end else if (press[i]) begin
                    Pending[i] <= 1'b1;
                end
            end
            Overrun <= (Overrun & ~{N{OvrClr}})
                     | (press & Pending & ~grant);
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            CmdValid <= 1'b0;
            CmdId    <= '0;
            ptr      <= IW'(N - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (|Pending) begin
                        CmdId    <= winner;
                        CmdValid <= 1'b1;
                        ptr      <= winner;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (CmdReady) begin
                        CmdValid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    CmdValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_arbiter.sv
// Bench for button_arbiter: timestamp-based reference model and a
// command scoreboard drained by a handshake monitor.
module tb_button_arbiter;

    localparam int N       = 4;
    localparam int LOCKOUT = 4;
    localparam int IW      = 2;

    logic          Clock;
    logic          ResetN;
    logic [N-1:0]  In;
    logic          CmdReady;
    logic          OvrClr;
    logic          CmdValid;
    logic [IW-1:0] CmdId;
    logic [N-1:0]  Pending;
    logic [N-1:0]  Overrun;

    button_arbiter #(.N(N), .LOCKOUT(LOCKOUT), .IW(IW)) dut (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .In      (In),
        .CmdReady(CmdReady),
        .OvrClr  (OvrClr),
        .CmdValid(CmdValid),
        .CmdId   (CmdId),
        .Pending (Pending),
        .Overrun (Overrun)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_q[$];
    int issued[$];

    logic [N-1:0] samples[$];
    int           ecount;
    int           last_press[N];
    logic [N-1:0] mpend;
    logic [N-1:0] movr;
    bit           mvalid;
    int           mptr;
    int           mid;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        samples.delete();
        ecount = 0;
        for (int i = 0; i < N; i++) last_press[i] = -1000;
        mpend  = '0;
        movr   = '0;
        mvalid = 1'b0;
        mptr   = N - 1;
        mid    = 0;
        exp_q.delete();
    endtask

    // One rising edge of the reference: a press is a 0->1 step of the
    // input as seen two edges late, unless within LOCKOUT edges of the last.
    task automatic model_step();
        logic [N-1:0] s2, s3, press, grant, npend;
        s2 = (ecount >= 2) ? samples[ecount-2] : '0;
        s3 = (ecount >= 3) ? samples[ecount-3] : '0;
        press = '0;
        for (int i = 0; i < N; i++) begin
            if (s2[i] && !s3[i] && (ecount - last_press[i] > LOCKOUT)) begin
                press[i] = 1'b1;
                last_press[i] = ecount;
            end
        end
        grant = '0;
        if (!mvalid && mpend != '0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (mpend[j]) begin
                    grant[j] = 1'b1;
                    mptr = j;
                    mid = j;
                    break;
                end
            end
            mvalid = 1'b1;
            exp_q.push_back(mid);
        end else if (mvalid && CmdReady) begin
            mvalid = 1'b0;
        end
        npend = mpend;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) npend[i] = press[i];
            else if (press[i]) npend[i] = 1'b1;
        end
        if (OvrClr) movr = '0;
        movr = movr | (press & mpend & ~grant);
        mpend = npend;
        samples.push_back(In);
        ecount++;
    endtask

    task automatic cycle(input logic [N-1:0] vin, input bit vrdy, input bit vclr);
        In = vin;
        CmdReady = vrdy;
        OvrClr = vclr;
        @(posedge Clock);
        if (ResetN) model_step();
        else model_reset();
        #1;
        chk("cmd_valid", int'(CmdValid), int'(mvalid));
        chk("pending", int'(Pending), int'(mpend));
        chk("overrun", int'(Overrun), int'(movr));
        if (mvalid) chk("cmd_id_stable", int'(CmdId), mid);
    endtask

    task automatic do_reset();
        ResetN = 1'b0;
        model_reset();
        repeat (3) cycle('0, 1'b0, 1'b0);
        chk("rst_valid", int'(CmdValid), 0);
        chk("rst_id", int'(CmdId), 0);
        chk("rst_pending", int'(Pending), 0);
        chk("rst_overrun", int'(Overrun), 0);
        ResetN = 1'b1;
    endtask

    always @(negedge Clock) begin
        if (ResetN && CmdValid && CmdReady) begin
            if (exp_q.size() == 0) begin
                chk("cmd_unexpected", int'(CmdId), -1);
            end else begin
                chk("cmd_id", int'(CmdId), exp_q.pop_front());
            end
            issued.push_back(int'(CmdId));
        end
    end

    initial begin
        int cnt;
        logic [N-1:0] cur;
        In = '0;
        CmdReady = 1'b0;
        OvrClr = 1'b0;

        // Reset, latency and handshake hold
        do_reset();
        cycle(4'b0100, 1'b0, 1'b0);
        cycle(4'b0100, 1'b0, 1'b0);
        chk("lat_pending_k1", int'(Pending), 0);
        cycle(4'b0100, 1'b0, 1'b0);
        chk("lat_pending_k2", int'(Pending), 4);
        cycle(4'b0100, 1'b0, 1'b0);
        chk("lat_valid_k3", int'(CmdValid), 1);
        chk("lat_id_k3", int'(CmdId), 2);
        chk("lat_pending_k3", int'(Pending), 0);
        repeat (5) begin
            cycle(4'b0100, 1'b0, 1'b0);
            chk("hold_valid", int'(CmdValid), 1);
            chk("hold_id", int'(CmdId), 2);
        end
        cycle(4'b0100, 1'b1, 1'b0);
        chk("hs_valid_low", int'(CmdValid), 0);
        repeat (6) cycle(4'b0100, 1'b1, 1'b0);
        chk("held_single_press", int'(Pending), 0);
        chk("held_no_offer", int'(CmdValid), 0);

        // Round-robin fairness, twice
        do_reset();
        issued.delete();
        for (int r = 0; r < 2; r++) begin
            cycle(4'b1111, 1'b1, 1'b0);
            repeat (12) cycle('0, 1'b1, 1'b0);
        end
        chk("rr_count", issued.size(), 8);
        for (int i = 0; i < 8 && i < issued.size(); i++) begin
            chk("rr_order", issued[i], i % 4);
        end

        // Lockout on channel 1
        issued.delete();
        repeat (2) cycle(4'b0010, 1'b1, 1'b0);
        repeat (2) cycle(4'b0000, 1'b1, 1'b0);
        repeat (2) cycle(4'b0010, 1'b1, 1'b0);
        repeat (10) cycle(4'b0000, 1'b1, 1'b0);
        chk("lock_one_cmd", issued.size(), 1);
        chk("lock_no_overrun", int'(Overrun[1]), 0);
        repeat (2) cycle(4'b0010, 1'b1, 1'b0);
        repeat (8) cycle(4'b0000, 1'b1, 1'b0);
        chk("lock_repress", issued.size(), 2);

        // Overrun while channel 0 is stuck on offer
        do_reset();
        cycle(4'b0001, 1'b0, 1'b0);
        repeat (4) cycle('0, 1'b0, 1'b0);
        chk("ovr_offer0", int'(CmdId), 0);
        cycle(4'b1000, 1'b0, 1'b0);
        repeat (7) cycle('0, 1'b0, 1'b0);
        cycle(4'b1000, 1'b0, 1'b0);
        repeat (4) cycle('0, 1'b0, 1'b0);
        chk("ovr_pending3", int'(Pending[3]), 1);
        chk("ovr_flag3", int'(Overrun[3]), 1);
        cycle('0, 1'b0, 1'b1);
        chk("ovrclr_overrun", int'(Overrun), 0);
        chk("ovrclr_pending3", int'(Pending[3]), 1);

        // Asynchronous reset between edges while offering
        chk("pre_rst_valid", int'(CmdValid), 1);
        #2;
        ResetN = 1'b0;
        #1;
        chk("async_valid", int'(CmdValid), 0);
        chk("async_pending", int'(Pending), 0);
        chk("async_overrun", int'(Overrun), 0);
        model_reset();
        repeat (2) cycle('0, 1'b0, 1'b0);
        ResetN = 1'b1;
        repeat (4) cycle('0, 1'b1, 1'b0);

        // Randomised traffic
        cur = '0;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(5) == 0) cur[i] = ~cur[i];
            end
            cycle(cur, ($urandom_range(2) != 0), ($urandom_range(19) == 0));
        end

        repeat (30) cycle('0, 1'b1, 1'b0);
        cnt = exp_q.size();
        chk("queue_drained", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
